ads_frame_reader: RTL and testbench

Upstream acquisition stage for the cursor pipeline. It reads one ADS1299-style SPI frame per DRDY event: a 24-bit status word followed by 8 channels of 24-bit samples. It then presents the samples one channel at a time as `raw_adc_in` / `adc_channel_sel` / `adc_data_ready`, the exact ADC inputs consumed by the cursor top. It is the SPI master, and it also flags malformed frames and missed DRDY events.

---
 rtl/ads_frame_reader_pkg.sv | 23 ++
 rtl/ads_frame_reader_if.sv | 38 +++
 rtl/ads_frame_reader_sync.sv | 31 +++
 rtl/ads_frame_reader.sv | 168 ++++++++++++++++
 tb/tb_ads_frame_reader.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/ads_frame_reader_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : boreal_adc_pkg
//  Purpose   : Shared constants and state encoding for the ADS frame reader.
//  Revision  : 1.0  initial release
// ============================================================================
package boreal_adc_pkg;

    // A frame is one status word followed by eight channel words.
    localparam int         FRAME_BITS = 216;
    localparam int         WORD_BITS  = 24;
    // Upper nibble every well-formed status word carries.
    localparam logic [3:0] STATUS_HDR = 4'hC;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CS_SETUP = 2'd1,
        SHIFT    = 2'd2,
        CS_HOLD  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ads_frame_reader_if.sv
`default_nettype none
// ============================================================================
//  Interface : ads_frame_reader_if
//  Purpose   : SPI pins, DRDY/enable inputs and the per-channel sample bus of
//              the ADS frame reader.
//  Revision  : 1.0  initial release
// ============================================================================
interface ads_frame_reader_if;
    import boreal_adc_pkg::*;

    logic                 enable;
    logic                 drdy_n;
    logic                 spi_miso;
    logic                 spi_sclk;
    logic                 spi_cs_n;
    logic [WORD_BITS-1:0] raw_adc_in;
    logic [2:0]           adc_channel_sel;
    logic                 adc_data_ready;
    logic [WORD_BITS-1:0] status_word;
    logic                 frame_done;
    logic                 frame_error;
    logic                 overrun;

    // Reader side: drives the SPI clock/select and the sample outputs.
    modport master (
        input  enable, drdy_n, spi_miso,
        output spi_sclk, spi_cs_n, raw_adc_in, adc_channel_sel,
               adc_data_ready, status_word, frame_done, frame_error, overrun
    );

    // ADC / consumer side.
    modport slave (
        output enable, drdy_n, spi_miso,
        input  spi_sclk, spi_cs_n, raw_adc_in, adc_channel_sel,
               adc_data_ready, status_word, frame_done, frame_error, overrun
    );
endinterface
`default_nettype wire

// File: rtl/ads_frame_reader_sync.sv
`default_nettype none
// ============================================================================
//  Module    : sync_2ff
//  Purpose   : Generic two-flop synchronizer for a single asynchronous input.
//  Revision  : 1.0  initial release
// ============================================================================
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  wire clk,
    input  wire rst_n,
    input  wire i_d,
    output wire o_q
);
    logic r_meta;
    logic r_sync;

    // Two back-to-back flops resolve metastability of the async input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;
endmodule
`default_nettype wire

// File: rtl/ads_frame_reader.sv
`default_nettype none
// ============================================================================
//  Module    : ads_frame_reader
//  Purpose   : SPI master that reads one ADS1299-style frame per DRDY event
//              and presents the eight channel samples one at a time.
//  Revision  : 1.0  initial release
// ============================================================================
module ads_frame_reader
    import boreal_adc_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int NUM_CH  = 8
) (
    input  wire               clk,
    input  wire               rst_n,
    ads_frame_reader_if.master bus
);
    localparam int         c_FRAME_LEN = WORD_BITS * (NUM_CH + 1);
    localparam logic [7:0] c_DIV_MAX   = 8'(CLK_DIV - 1);
    localparam logic [7:0] c_LAST_BIT  = 8'(c_FRAME_LEN - 1);
    localparam logic [4:0] c_WORD_LAST = 5'(WORD_BITS - 1);

    state_t                r_state;
    state_t                w_state_next;
    logic                  w_drdy_sync;
    logic                  r_drdy_d;
    logic                  w_drdy_fall;
    logic [7:0]            r_div;
    logic                  w_div_end;
    logic                  r_sclk;
    logic                  w_sample;
    logic [7:0]            r_bit_cnt;
    logic                  r_last;
    logic [4:0]            r_wbit;
    logic [3:0]            r_word;
    logic [WORD_BITS-1:0]  r_shreg;
    logic [WORD_BITS-1:0]  w_word;
    logic                  w_word_end;
    logic [WORD_BITS-1:0]  r_raw;
    logic [2:0]            r_sel;
    logic                  r_ready;
    logic [WORD_BITS-1:0]  r_status;
    logic                  r_done;
    logic                  r_err;
    logic                  r_ovr;

    sync_2ff #(.RESET_VAL(1'b1)) u_drdy_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (bus.drdy_n),
        .o_q   (w_drdy_sync)
    );

    // Delayed copy of synchronized DRDY for falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_drdy_d <= 1'b1;
        else        r_drdy_d <= w_drdy_sync;
    end

    assign w_drdy_fall = r_drdy_d & ~w_drdy_sync;
    assign w_div_end   = (r_div == c_DIV_MAX);
    assign w_word      = {r_shreg[WORD_BITS-2:0], bus.spi_miso};
    assign w_word_end  = w_sample && (r_wbit == c_WORD_LAST);

    // Frame sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    // Next state; a sample strobe is the SCLK high-to-low edge inside SHIFT.
    // SHIFT ends after the low half of the final pulse, not at its sample.
    always_comb begin
        w_state_next = r_state;
        w_sample     = 1'b0;
        case (r_state)
            IDLE:     if (w_drdy_fall && bus.enable) w_state_next = CS_SETUP;
            CS_SETUP: if (w_div_end) w_state_next = SHIFT;
            SHIFT: begin
                w_sample = w_div_end & r_sclk;
                if (w_div_end && !r_sclk && r_last) w_state_next = CS_HOLD;
            end
            CS_HOLD:  if (w_div_end) w_state_next = IDLE;
            default:  w_state_next = IDLE;
        endcase
    end

    // SCLK half-period divider and SCLK generation (CPOL=0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div  <= 8'd0;
            r_sclk <= 1'b0;
        end else begin
            if (r_state == IDLE || w_div_end) r_div <= 8'd0;
            else                              r_div <= r_div + 8'd1;
            case (r_state)
                CS_SETUP: r_sclk <= w_div_end;
                SHIFT:    if (w_div_end) r_sclk <= ~r_sclk & ~r_last;
                default:  r_sclk <= 1'b0;
            endcase
        end
    end

    // Bit/word position tracking and MSB-first shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt <= 8'd0;
            r_last    <= 1'b0;
            r_wbit    <= 5'd0;
            r_word    <= 4'd0;
            r_shreg   <= '0;
        end else if (r_state == IDLE) begin
            r_bit_cnt <= 8'd0;
            r_last    <= 1'b0;
            r_wbit    <= 5'd0;
            r_word    <= 4'd0;
            r_shreg   <= '0;
        end else if (w_sample) begin
            r_shreg <= w_word;
            if (r_bit_cnt == c_LAST_BIT) r_last    <= 1'b1;
            else                         r_bit_cnt <= r_bit_cnt + 8'd1;
            if (r_wbit == c_WORD_LAST) begin
                r_wbit <= 5'd0;
                r_word <= r_word + 4'd1;
            end else begin
                r_wbit <= r_wbit + 5'd1;
            end
        end
    end

    // Word 0 is the status word; words 1..8 are emitted as channels 0..7.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_raw    <= '0;
            r_sel    <= 3'd0;
            r_ready  <= 1'b0;
            r_status <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_ovr    <= 1'b0;
        end else begin
            r_ready <= w_word_end && (r_word != 4'd0);
            if (w_word_end) begin
                if (r_word == 4'd0) begin
                    r_status <= w_word;
                end else begin
                    r_raw <= w_word;
                    r_sel <= 3'(r_word - 4'd1);
                end
            end
            r_done <= (r_state == CS_HOLD) && w_div_end;
            r_err  <= (r_state == CS_HOLD) && w_div_end &&
                      (r_status[WORD_BITS-1:WORD_BITS-4] != STATUS_HDR);
            r_ovr  <= w_drdy_fall && (r_state != IDLE);
        end
    end

    assign bus.spi_sclk        = r_sclk;
    assign bus.spi_cs_n        = (r_state == IDLE);
    assign bus.raw_adc_in      = r_raw;
    assign bus.adc_channel_sel = r_sel;
    assign bus.adc_data_ready  = r_ready;
    assign bus.status_word     = r_status;
    assign bus.frame_done      = r_done;
    assign bus.frame_error     = r_err;
    assign bus.overrun         = r_ovr;
endmodule
`default_nettype wire

// File: tb/tb_ads_frame_reader.sv
`default_nettype none
// ============================================================================
//  Module    : tb_ads_frame_reader
//  Purpose   : Self-checking bench for ads_frame_reader with an ADC model.
//  Revision  : 1.0  initial release
// ============================================================================
module tb_ads_frame_reader;
    localparam int D         = 4;
    localparam int FRAME_CYC = D * 434;

    typedef struct {
        logic [23:0]      status;
        logic [7:0][23:0] ch;
        logic             exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t vecs [8];

    logic [215:0] model_frame = '0;
    int           model_idx   = 0;

    ads_frame_reader_if bus ();

    ads_frame_reader #(.CLK_DIV(D), .NUM_CH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // ADC model: mode 1, next bit launched on each SCLK rise, MSB first.
    always @(negedge bus.spi_cs_n or posedge bus.spi_sclk) begin
        if (bus.spi_sclk) begin
            if (model_idx < 216) bus.spi_miso = model_frame[215 - model_idx];
            model_idx++;
        end else begin
            model_idx    = 0;
            bus.spi_miso = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_sclk"},   32'(bus.spi_sclk), 32'd0);
        chk({tag, "_cs_n"},   32'(bus.spi_cs_n), 32'd1);
        chk({tag, "_raw"},    32'(bus.raw_adc_in), 32'd0);
        chk({tag, "_sel"},    32'(bus.adc_channel_sel), 32'd0);
        chk({tag, "_status"}, 32'(bus.status_word), 32'd0);
        chk({tag, "_pulses"}, 32'({bus.adc_data_ready, bus.frame_done,
                                   bus.frame_error, bus.overrun}), 32'd0);
    endtask

    // One DRDY-triggered frame; optional overrun edge, enable drop or reset
    // at a given cycle offset from spi_cs_n falling.
    task automatic run_frame(input vec_t v, input int ovr_at, input int en_drop_at,
                             input int rst_at);
        int n;
        int off;
        int nrdy;
        int novr;
        int done_off;
        int err_at_done;
        int bits_done;
        int exp_rdy;
        int cs_low;
        model_frame[215 -: 24] = v.status;
        for (int k = 0; k < 8; k++) model_frame[191 - 24*k -: 24] = v.ch[k];
        @(negedge clk);
        bus.drdy_n = 1'b0;
        n = 0;
        while (bus.spi_cs_n && n < 20) begin
            @(negedge clk);
            n++;
        end
        bus.drdy_n = 1'b1;
        chk("drdy_to_cs", 32'(n), 32'd3);
        if (n >= 20) return;
        off = 0; nrdy = 0; novr = 0; done_off = -1; err_at_done = 0;
        while (off < FRAME_CYC + 40) begin
            @(negedge clk);
            off++;
            if (bus.adc_data_ready) begin
                if (nrdy < 8) begin
                    chk($sformatf("sel%0d", nrdy), 32'(bus.adc_channel_sel), 32'(nrdy));
                    chk($sformatf("data%0d", nrdy), 32'(bus.raw_adc_in), 32'(v.ch[nrdy]));
                    chk($sformatf("rdy_time%0d", nrdy), 32'(off), 32'(48 * D * (nrdy + 2)));
                end
                nrdy++;
            end
            if (bus.overrun) novr++;
            if (bus.frame_done) begin
                done_off    = off;
                err_at_done = int'(bus.frame_error);
                break;
            end
            if (off == ovr_at)     bus.drdy_n = 1'b0;
            if (off == ovr_at + 6) bus.drdy_n = 1'b1;
            if (off == en_drop_at) bus.enable = 1'b0;
            if (off == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_sclk_now", 32'(bus.spi_sclk), 32'd0);
                chk("rst_cs_now", 32'(bus.spi_cs_n), 32'd1);
                break;
            end
        end
        if (rst_at > 0) begin
            bits_done = (rst_at - D) / (2 * D);
            exp_rdy   = (bits_done >= 48) ? (bits_done - 24) / 24 : 0;
            chk("rst_rdy_count", 32'(nrdy), 32'(exp_rdy));
            n = 0;
            repeat (5) begin
                @(negedge clk);
                if (bus.adc_data_ready) n++;
            end
            chk("rst_no_rdy", 32'(n), 32'd0);
            chk_reset("midrst");
            rst_n = 1'b1;
            repeat (5) @(negedge clk);
        end else begin
            chk("done_time", 32'(done_off), 32'(FRAME_CYC));
            chk("cs_high_at_done", 32'(bus.spi_cs_n), 32'd1);
            chk("frame_error", 32'(err_at_done), 32'(v.exp_err));
            chk("status_word", 32'(bus.status_word), 32'(v.status));
            chk("rdy_count", 32'(nrdy), 32'd8);
            chk("overrun_count", 32'(novr), (ovr_at > 0) ? 32'd1 : 32'd0);
            @(negedge clk);
            chk("hold_raw", 32'(bus.raw_adc_in), 32'(v.ch[7]));
            chk("hold_sel", 32'(bus.adc_channel_sel), 32'd7);
            if (ovr_at > 0) begin
                cs_low = 0;
                repeat (40) begin
                    @(negedge clk);
                    if (!bus.spi_cs_n) cs_low++;
                end
                chk("no_second_frame", 32'(cs_low), 32'd0);
            end
        end
        bus.enable = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        int cs_low;
        int novr;
        rst_n      = 1'b0;
        bus.enable = 1'b1;
        bus.drdy_n = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        vecs[0].status = 24'hC00000;
        for (int k = 0; k < 8; k++) vecs[0].ch[k] = 24'h100000 + 24'(k);
        vecs[0].exp_err = 1'b0;
        vecs[1] = vecs[0];
        vecs[1].status  = 24'hA00000;
        vecs[1].exp_err = 1'b1;
        vecs[2].status = 24'hC12345;
        for (int k = 0; k < 8; k++) vecs[2].ch[k] = 24'($urandom);
        vecs[2].ch[7]   = 24'h800000;
        vecs[2].exp_err = 1'b0;
        vecs[3].status = 24'hCFFFFF;
        for (int k = 0; k < 8; k++) vecs[3].ch[k] = 24'($urandom);
        vecs[3].ch[0]   = 24'h800000;
        vecs[3].ch[7]   = 24'hFFFFFF;
        vecs[3].exp_err = 1'b0;
        for (int i = 4; i < 8; i++) begin
            vecs[i].status[23:20] = ($urandom_range(0, 1) == 1) ? 4'hC : 4'($urandom_range(0, 15));
            vecs[i].status[19:0]  = 20'($urandom);
            for (int k = 0; k < 8; k++) vecs[i].ch[k] = 24'($urandom);
            vecs[i].exp_err = (vecs[i].status[23:20] != 4'hC);
        end

        for (int i = 0; i < 8; i++) run_frame(vecs[i], 0, 0, 0);

        // DRDY edge mid-frame.
        run_frame(vecs[0], 500, 0, 0);
        // Enable dropped mid-frame.
        run_frame(vecs[2], 0, 300, 0);

        // DRDY while disabled is ignored entirely.
        bus.enable = 1'b0;
        @(negedge clk);
        bus.drdy_n = 1'b0;
        cs_low = 0; novr = 0;
        repeat (40) begin
            @(negedge clk);
            if (!bus.spi_cs_n) cs_low++;
            if (bus.overrun) novr++;
        end
        bus.drdy_n = 1'b1;
        chk("disabled_cs_low", 32'(cs_low), 32'd0);
        chk("disabled_overrun", 32'(novr), 32'd0);
        bus.enable = 1'b1;
        repeat (10) @(negedge clk);

        // Reset at the start of bit 100, then a clean frame.
        run_frame(vecs[3], 0, 0, D + 2 * 100 * D);
        run_frame(vecs[0], 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
